uvma_reset_gen: RTL and testbench

//  Reset pulse generator driving the active-low reset line observed on uvma_reset_if.
//  - Sits directly upstream of the interface: a sequence or agent driver requests a pulse via a valid/ready handshake.
//  - Block asserts rst_n_o for an exact cycle count, enforces a minimum inter-pulse gap and reports completion.
//  - Optional power-on pulse is issued automatically after reset_n releases.

---
 rtl/uvma_reset_gen_pkg.sv | 15 +
 rtl/uvma_reset_gen_if.sv | 26 ++
 rtl/uvma_reset_gen_dcnt.sv | 26 ++
 rtl/uvma_reset_gen.sv | 134 +++++++++++++
 tb/tb_uvma_reset_gen.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/uvma_reset_gen_pkg.sv
// Shared types and helpers for the reset pulse generator.
package uvma_reset_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        HOLD   = 2'd2
    } uvma_reset_gen_state_t;

    // Width of the hold-off counter; never below one bit so HOLDOFF==0 still elaborates.
    function automatic int hold_w(input int holdoff);
        return (holdoff < 1) ? 1 : $clog2(holdoff + 1);
    endfunction

endpackage

// File: rtl/uvma_reset_gen_if.sv
// Request handshake and generated-reset status bundle between a requester and the generator.
interface uvma_reset_gen_if #(
    parameter int LEN_W = 16,
    parameter int CNT_W = 16
) ();

    logic             req_valid;
    logic             req_ready;
    logic [LEN_W-1:0] req_len;
    logic             rst_n_o;
    logic             rst_active;
    logic             done;
    logic             busy;
    logic [CNT_W-1:0] pulse_cnt;

    modport master (
        output req_valid, req_len,
        input  req_ready, rst_n_o, rst_active, done, busy, pulse_cnt
    );

    modport slave (
        input  req_valid, req_len,
        output req_ready, rst_n_o, rst_active, done, busy, pulse_cnt
    );

endinterface

// File: rtl/uvma_reset_gen_dcnt.sv
// Loadable down-counter that flags when the current count is one.
// Load wins over decrement; no reset of its own, the owner loads it when needed.
module uvma_reset_gen_dcnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         is_one
);

    logic [W-1:0] cnt;

    // Load a fresh count or step down by one.
    always_ff @(posedge clk) begin
        if (load) begin
            cnt <= value;
        end else if (dec) begin
            cnt <= cnt - W'(1);
        end
    end

    assign is_one = (cnt == W'(1));

endmodule

// File: rtl/uvma_reset_gen.sv
// Reset pulse generator: drives an active-low reset for an exact number of cycles
// on request, enforces a hold-off gap, counts completed pulses and can issue a
// power-on pulse by itself. All outputs come straight from flops.
import uvma_reset_gen_pkg::*;

module uvma_reset_gen #(
    parameter int LEN_W       = 16,
    parameter int DEFAULT_LEN = 16,
    parameter int HOLDOFF     = 4,
    parameter int CNT_W       = 16,
    parameter int POR_EN      = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    uvma_reset_gen_if.slave bus
);

    localparam int HOLD_W = hold_w(HOLDOFF);

    uvma_reset_gen_state_t state;

    logic             rst_n_q;
    logic             rst_active_q;
    logic             done_q;
    logic             busy_q;
    logic             req_ready_q;
    logic [CNT_W-1:0] pulse_cnt_q;

    logic [LEN_W-1:0] eff_len;
    logic [LEN_W-1:0] len_load_val;
    logic             len_load;
    logic             len_dec;
    logic             len_is_one;

    logic             hold_load;
    logic             hold_dec;
    logic             hold_is_one;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A zero request length means "use the default pulse length".
    assign eff_len = (bus.req_len == '0) ? LEN_W'(DEFAULT_LEN) : bus.req_len;

    // The length counter tracks req_len while idle so the handshake edge captures it;
    // during block reset it is primed with the power-on length.
    assign len_load     = !reset_n || (state == IDLE);
    assign len_load_val = !reset_n ? LEN_W'(DEFAULT_LEN) : eff_len;
    assign len_dec      = (state == ASSERT);

    // The hold counter sits preloaded outside HOLD, so it starts counting on the done edge.
    assign hold_load = (state != HOLD);
    assign hold_dec  = (state == HOLD);

    uvma_reset_gen_dcnt #(.W(LEN_W)) u_len_cnt (
        .clk    (clk),
        .load   (len_load),
        .value  (len_load_val),
        .dec    (len_dec),
        .is_one (len_is_one)
    );

    uvma_reset_gen_dcnt #(.W(HOLD_W)) u_hold_cnt (
        .clk    (clk),
        .load   (hold_load),
        .value  (HOLD_W'(HOLDOFF)),
        .dec    (hold_dec),
        .is_one (hold_is_one)
    );

    // FSM with registered outputs; block reset keeps rst_n_o low when a power-on pulse follows.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= (POR_EN != 0) ? ASSERT : IDLE;
            rst_n_q      <= (POR_EN == 0);
            rst_active_q <= (POR_EN != 0);
            busy_q       <= (POR_EN != 0);
            req_ready_q  <= (POR_EN == 0);
            done_q       <= 1'b0;
            pulse_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        state        <= ASSERT;
                        rst_n_q      <= 1'b0;
                        rst_active_q <= 1'b1;
                        busy_q       <= 1'b1;
                        req_ready_q  <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (len_is_one) begin
                        rst_n_q      <= 1'b1;
                        rst_active_q <= 1'b0;
                        done_q       <= 1'b1;
                        pulse_cnt_q  <= sat_inc(pulse_cnt_q);
                        if (HOLDOFF == 0) begin
                            state       <= IDLE;
                            busy_q      <= 1'b0;
                            req_ready_q <= 1'b1;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (hold_is_one) begin
                        state       <= IDLE;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    rst_n_q      <= 1'b1;
                    rst_active_q <= 1'b0;
                    busy_q       <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rst_n_o    = rst_n_q;
    assign bus.rst_active = rst_active_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.req_ready  = req_ready_q;
    assign bus.pulse_cnt  = pulse_cnt_q;

endmodule

// File: tb/tb_uvma_reset_gen.sv
// Directed bench for uvma_reset_gen: three instances cover power-on with hold-off,
// back-to-back pulses without hold-off, and a narrow saturating pulse counter.
module tb_uvma_reset_gen;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic rst_c = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uvma_reset_gen_if #(.LEN_W(16), .CNT_W(16)) if_a ();
    uvma_reset_gen_if #(.LEN_W(16), .CNT_W(16)) if_b ();
    uvma_reset_gen_if #(.LEN_W(16), .CNT_W(2))  if_c ();

    uvma_reset_gen #(.LEN_W(16), .DEFAULT_LEN(16), .HOLDOFF(4), .CNT_W(16), .POR_EN(1)) dut_a (
        .clk(clk), .reset_n(rst_a), .bus(if_a.slave)
    );
    uvma_reset_gen #(.LEN_W(16), .DEFAULT_LEN(16), .HOLDOFF(0), .CNT_W(16), .POR_EN(0)) dut_b (
        .clk(clk), .reset_n(rst_b), .bus(if_b.slave)
    );
    uvma_reset_gen #(.LEN_W(16), .DEFAULT_LEN(16), .HOLDOFF(1), .CNT_W(2), .POR_EN(0)) dut_c (
        .clk(clk), .reset_n(rst_c), .bus(if_c.slave)
    );

    // Flag order: {rst_n_o, rst_active, done, busy, req_ready}
    typedef struct {
        bit         rn;
        bit         vld;
        int         len;
        int         n;
        logic [4:0] f;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [4:0] flags_a();
        return {if_a.rst_n_o, if_a.rst_active, if_a.done, if_a.busy, if_a.req_ready};
    endfunction
    function automatic logic [4:0] flags_b();
        return {if_b.rst_n_o, if_b.rst_active, if_b.done, if_b.busy, if_b.req_ready};
    endfunction
    function automatic logic [4:0] flags_c();
        return {if_c.rst_n_o, if_c.rst_active, if_c.done, if_c.busy, if_c.req_ready};
    endfunction

    task automatic chk(input string name, input logic [4:0] af, input logic [4:0] ef,
                       input int ac, input int ec);
        checks++;
        if (af !== ef || ac != ec) begin
            errors++;
            $display("FAIL %s: got flags=%b cnt=%0d, expected flags=%b cnt=%0d",
                     name, af, ac, ef, ec);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int prev;
        int exp_cnt;

        if_a.req_valid = 1'b0; if_a.req_len = '0;
        if_b.req_valid = 1'b0; if_b.req_len = '0;
        if_c.req_valid = 1'b0; if_c.req_len = '0;

        // ---- Instance A: table of {reset_n, valid, len, cycles, flags, pulse_cnt}
        // Power-on: reset values, then 16 low cycles counted from release, done, 4 hold cycles.
        tbl.push_back('{0, 0, 0,  3, 5'b01010, 0});
        tbl.push_back('{1, 0, 0, 15, 5'b01010, 0});
        tbl.push_back('{1, 0, 0,  1, 5'b10110, 1});
        tbl.push_back('{1, 0, 0,  3, 5'b10010, 1});
        tbl.push_back('{1, 0, 0,  1, 5'b10001, 1});
        tbl.push_back('{1, 0, 0,  2, 5'b10001, 1});
        // req_len=5; req_len changed mid-pulse must be ignored.
        tbl.push_back('{1, 1, 5,  1, 5'b01010, 1});
        tbl.push_back('{1, 0, 9,  4, 5'b01010, 1});
        tbl.push_back('{1, 0, 9,  1, 5'b10110, 2});
        tbl.push_back('{1, 0, 0,  3, 5'b10010, 2});
        tbl.push_back('{1, 0, 0,  1, 5'b10001, 2});
        // req_len=1 single-cycle pulse; valid held through hold is not accepted.
        tbl.push_back('{1, 1, 1,  1, 5'b01010, 2});
        tbl.push_back('{1, 1, 1,  1, 5'b10110, 3});
        tbl.push_back('{1, 1, 1,  3, 5'b10010, 3});
        tbl.push_back('{1, 1, 1,  1, 5'b10001, 3});
        // req_len=0 gives the default 16-cycle pulse.
        tbl.push_back('{1, 1, 0,  1, 5'b01010, 3});
        tbl.push_back('{1, 0, 0, 15, 5'b01010, 3});
        tbl.push_back('{1, 0, 0,  1, 5'b10110, 4});
        tbl.push_back('{1, 0, 0,  3, 5'b10010, 4});
        tbl.push_back('{1, 0, 0,  1, 5'b10001, 4});
        // 10-cycle pulse cut by reset_n at its cycle 7: line stays low, no done, count cleared,
        // then a fresh power-on pulse.
        tbl.push_back('{1, 1, 10, 1, 5'b01010, 4});
        tbl.push_back('{1, 0, 0,  6, 5'b01010, 4});
        tbl.push_back('{0, 0, 0,  2, 5'b01010, 0});
        tbl.push_back('{1, 0, 0, 15, 5'b01010, 0});
        tbl.push_back('{1, 0, 0,  1, 5'b10110, 1});
        tbl.push_back('{1, 0, 0,  3, 5'b10010, 1});
        tbl.push_back('{1, 0, 0,  1, 5'b10001, 1});
        // Reset during hold: back to power-on state immediately.
        tbl.push_back('{1, 1, 2,  1, 5'b01010, 1});
        tbl.push_back('{1, 0, 0,  1, 5'b01010, 1});
        tbl.push_back('{1, 0, 0,  1, 5'b10110, 2});
        tbl.push_back('{1, 0, 0,  1, 5'b10010, 2});
        tbl.push_back('{0, 0, 0,  1, 5'b01010, 0});

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                rst_a          = tbl[i].rn;
                if_a.req_valid = tbl[i].vld;
                if_a.req_len   = 16'(tbl[i].len);
                step();
                chk($sformatf("a_row%0d_cyc%0d", i, k), flags_a(), tbl[i].f,
                    int'(if_a.pulse_cnt), tbl[i].cnt);
            end
        end
        rst_a = 1'b1;

        // ---- Instance B: HOLDOFF=0, valid held, len 3 -> 3 low / 1 high per period.
        step();
        chk("b_reset", flags_b(), 5'b10001, int'(if_b.pulse_cnt), 0);
        rst_b = 1'b1;
        if_b.req_valid = 1'b1;
        if_b.req_len   = 16'd3;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 3; k++) begin
                step();
                chk($sformatf("b_low_p%0d_c%0d", p, k), flags_b(), 5'b01010,
                    int'(if_b.pulse_cnt), p);
            end
            step();
            chk($sformatf("b_high_p%0d", p), flags_b(), 5'b10101,
                int'(if_b.pulse_cnt), p + 1);
        end
        if_b.req_valid = 1'b0;
        step();
        chk("b_idle", flags_b(), 5'b10001, int'(if_b.pulse_cnt), 3);

        // ---- Instance C: CNT_W=2, HOLDOFF=1, len 2; counter saturates at 3.
        step();
        chk("c_reset", flags_c(), 5'b10001, int'(if_c.pulse_cnt), 0);
        rst_c = 1'b1;
        if_c.req_valid = 1'b1;
        if_c.req_len   = 16'd2;
        prev = 0;
        for (int p = 0; p < 5; p++) begin
            exp_cnt = (p + 1 > 3) ? 3 : p + 1;
            for (int k = 0; k < 2; k++) begin
                step();
                chk($sformatf("c_low_p%0d_c%0d", p, k), flags_c(), 5'b01010,
                    int'(if_c.pulse_cnt), prev);
            end
            step();
            chk($sformatf("c_done_p%0d", p), flags_c(), 5'b10110,
                int'(if_c.pulse_cnt), exp_cnt);
            step();
            chk($sformatf("c_ready_p%0d", p), flags_c(), 5'b10001,
                int'(if_c.pulse_cnt), exp_cnt);
            prev = exp_cnt;
        end
        if_c.req_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
